mem_arbiter: RTL and testbench

Arbitrates the single word-wide memory port between two requesters: instruction fetch (IF) and load/store (LS). Round-robin arbitration, one outstanding transaction, fixed-latency memory. It sits between the processor's fetch/LSU logic and the byte-addressed memory array, and replaces direct combinational array indexing with a sequenced valid/ready access.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-wide, fixed-latency memory port between
// instruction fetch (IF) and load/store (LS); one transaction in flight at a time.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 18,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  input  logic [31:0]           if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_resp_valid,
  output logic [31:0]           if_resp_data,
  output logic                  if_resp_err,
  input  logic                  ls_req_valid,
  input  logic                  ls_req_we,
  input  logic [31:0]           ls_req_addr,
  input  logic [31:0]           ls_req_wdata,
  input  logic [3:0]            ls_req_wstrb,
  output logic                  ls_req_ready,
  output logic                  ls_resp_valid,
  output logic [31:0]           ls_resp_data,
  output logic                  ls_resp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    last_ls_reg;
  logic                    owner_ls_reg;
  logic                    we_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [31:0]             wdata_reg;
  logic [3:0]              wstrb_reg;
  logic                    if_resp_reg, ls_resp_reg, err_reg;
  logic [31:0]             rdata_reg;

  logic                    idle, grant_if, grant_ls, hs_if, hs_ls, hs, aligned;
  logic [31:0]             req_addr;

  // On a tie the requester that did not win last time gets the port.
  assign idle     = (state_reg == IDLE);
  assign grant_if = if_req_valid && (!ls_req_valid || last_ls_reg);
  assign grant_ls = ls_req_valid && (!if_req_valid || !last_ls_reg);
  assign hs_if    = idle && grant_if && !rst;
  assign hs_ls    = idle && grant_ls && !rst;
  assign hs       = hs_if || hs_ls;
  assign req_addr = hs_ls ? ls_req_addr : if_req_addr;
  assign aligned  = (req_addr[1:0] == 2'b00);

  generate
    if (ADDR_WIDTH < 32) begin : g_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE:    if (hs && aligned) state_next = ACCESS;
      ACCESS: begin
        state_next = WAIT;
        cnt_next   = CNT_INIT;
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = IDLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      last_ls_reg  <= 1'b1;
      owner_ls_reg <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 32'h0;
      wstrb_reg    <= 4'h0;
      if_resp_reg  <= 1'b0;
      ls_resp_reg  <= 1'b0;
      err_reg      <= 1'b0;
      rdata_reg    <= 32'h0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      if_resp_reg <= 1'b0;
      ls_resp_reg <= 1'b0;
      if (hs) begin
        last_ls_reg  <= hs_ls;
        owner_ls_reg <= hs_ls;
        addr_reg     <= req_addr[ADDR_WIDTH-1:0];
        we_reg       <= hs_ls && ls_req_we;
        wdata_reg    <= hs_ls ? ls_req_wdata : 32'h0;
        wstrb_reg    <= hs_ls ? ls_req_wstrb : 4'h0;
        // Misaligned requests never touch memory; they are answered next cycle.
        if (!aligned) begin
          if_resp_reg <= hs_if;
          ls_resp_reg <= hs_ls;
          err_reg     <= 1'b1;
          rdata_reg   <= 32'h0;
        end
      end
      if (state_reg == WAIT && cnt_reg == 4'd0) begin
        if_resp_reg <= !owner_ls_reg;
        ls_resp_reg <= owner_ls_reg;
        err_reg     <= 1'b0;
        rdata_reg   <= we_reg ? 32'h0 : mem_rdata;
      end
    end
  end

  assign if_req_ready  = hs_if;
  assign ls_req_ready  = hs_ls;
  assign if_resp_valid = if_resp_reg;
  assign if_resp_data  = if_resp_reg ? rdata_reg : 32'h0;
  assign if_resp_err   = if_resp_reg && err_reg;
  assign ls_resp_valid = ls_resp_reg;
  assign ls_resp_data  = ls_resp_reg ? rdata_reg : 32'h0;
  assign ls_resp_err   = ls_resp_reg && err_reg;

  // The memory bus is held at zero outside the single strobe cycle.
  assign mem_en    = (state_reg == ACCESS);
  assign mem_we    = mem_en && we_reg;
  assign mem_addr  = mem_en ? addr_reg : '0;
  assign mem_wstrb = (mem_en && we_reg) ? wstrb_reg : 4'h0;
  assign mem_wdata = (mem_en && we_reg) ? wdata_reg : 32'h0;
  assign busy      = !idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory device plus a word-level
// reference of expected contents, directed scenarios and randomized single requests.
module tb_mem_arbiter;
  localparam int AW  = 18;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req_valid = 1'b0, if_req_ready, if_resp_valid, if_resp_err;
  logic [31:0]   if_req_addr = 32'h0, if_resp_data;
  logic          ls_req_valid = 1'b0, ls_req_we = 1'b0, ls_req_ready, ls_resp_valid, ls_resp_err;
  logic [31:0]   ls_req_addr = 32'h0, ls_req_wdata = 32'h0, ls_resp_data;
  logic [3:0]    ls_req_wstrb = 4'h0;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wstrb(ls_req_wstrb), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h00500093 : 32'(i) * 32'h9E3779B1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Memory device: byte-enable writes, reads appear LAT cycles after the strobe.
  logic [31:0] phys  [0:65535];
  bit          dirty [0:65535];
  logic [31:0] rd_pipe [0:LAT-1];
  logic [31:0] cur_word;
  assign mem_rdata = rd_pipe[LAT-1];
  assign cur_word  = dirty[mem_addr[AW-1:2]] ? phys[mem_addr[AW-1:2]] : init_word(int'(mem_addr[AW-1:2]));

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= 32'hBADC0DE5;
    if (mem_en) begin
      if (mem_we) begin
        phys[mem_addr[AW-1:2]]  <= merge(cur_word, mem_wdata, mem_wstrb);
        dirty[mem_addr[AW-1:2]] <= 1'b1;
      end else begin
        rd_pipe[0] <= cur_word;
      end
    end
  end

  // Reference contents, updated at each accepted aligned store.
  logic [31:0] ref_mem [0:65535];

  int            n_en = 0;
  int            last_en_cyc = -1;
  logic [AW-1:0] last_en_addr = '0;
  logic          last_en_we = 1'b0;
  logic [3:0]    last_en_wstrb = 4'h0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("both_ready", {if_req_ready, ls_req_ready} == 2'b11, 0);
      if (!mem_en) chk("bus_quiet", {mem_we, mem_wstrb, mem_wdata, mem_addr}, 0);
      else begin
        n_en++;
        last_en_cyc   = cyc;
        last_en_addr  = mem_addr;
        last_en_we    = mem_we;
        last_en_wstrb = mem_wstrb;
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return {if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
            ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
            mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata, busy};
  endfunction

  task automatic do_req(input bit is_ls, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input string tag, output logic [31:0] obs_data);
    int w, t_hs, en0;
    bit mis, got, rdy;
    logic [15:0] wi;
    logic [31:0] exp_data;
    mis = (addr[1:0] != 2'b00);
    wi  = addr[AW-1:2];
    obs_data = 32'hx;
    if (is_ls) begin
      ls_req_valid = 1'b1; ls_req_we = we; ls_req_addr = addr;
      ls_req_wdata = wdata; ls_req_wstrb = wstrb;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end
    #1;
    w = 0;
    rdy = is_ls ? ls_req_ready : if_req_ready;
    while (!rdy && w < 20) begin
      @(negedge clk); w++;
      rdy = is_ls ? ls_req_ready : if_req_ready;
    end
    chk({tag, "/accept"}, rdy, 1);
    t_hs = cyc;
    en0  = n_en;
    exp_data = (mis || (is_ls && we)) ? 32'h0 : ref_mem[wi];
    if (!mis && is_ls && we) ref_mem[wi] = merge(ref_mem[wi], wdata, wstrb);
    @(posedge clk); #1;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    if (!rdy) return;
    got = 1'b0; w = 0;
    while (!got && w < LAT + 6) begin
      @(negedge clk); w++;
      chk({tag, "/cross_resp"}, is_ls ? if_resp_valid : ls_resp_valid, 0);
      if (is_ls ? ls_resp_valid : if_resp_valid) got = 1'b1;
    end
    chk({tag, "/resp_seen"}, got, 1);
    if (!got) return;
    obs_data = is_ls ? ls_resp_data : if_resp_data;
    chk({tag, "/latency"}, cyc - t_hs, mis ? 1 : LAT + 2);
    chk({tag, "/data"}, obs_data, exp_data);
    chk({tag, "/err"}, is_ls ? ls_resp_err : if_resp_err, mis);
    chk({tag, "/mem_en_count"}, n_en - en0, mis ? 0 : 1);
    if (!mis) begin
      chk({tag, "/mem_en_cycle"}, last_en_cyc - t_hs, 1);
      chk({tag, "/mem_addr"}, last_en_addr, addr[AW-1:0]);
      chk({tag, "/mem_we_strb"}, {last_en_we, last_en_wstrb},
          {is_ls && we, (is_ls && we) ? wstrb : 4'h0});
    end
    $display("[TB] %s %s we=%0d addr=%h -> data=%h err=%0d lat=%0d", tag,
             is_ls ? "LS" : "IF", we, addr, obs_data,
             is_ls ? ls_resp_err : if_resp_err, cyc - t_hs);
  endtask

  initial begin
    logic [31:0] d, a;
    int grants, nif, nls, prev_g, en_snap;
    bit order [0:3];
    bit rl, rwe;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 32'h0;

    // Reset with both requesters already pending.
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h24;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Both held valid: strictly alternating grants starting with IF.
    grants = 0; nif = 0; nls = 0; prev_g = 0;
    for (int c = 0; c < 200 && grants < 4; c++) begin
      @(negedge clk);
      if (if_resp_valid) begin nif++; chk("alt/if_data", if_resp_data, ref_mem[4]); end
      if (ls_resp_valid) begin nls++; chk("alt/ls_data", ls_resp_data, ref_mem[9]); end
      if (if_req_ready || ls_req_ready) begin
        order[grants] = ls_req_ready;
        if (grants > 0) chk("alt/spacing", cyc - prev_g, LAT + 2);
        $display("[TB] alt grant %0d -> %s at cycle %0d", grants, ls_req_ready ? "LS" : "IF", cyc);
        prev_g = cyc;
        grants++;
      end
    end
    chk("alt/grant_count", grants, 4);
    chk("alt/order", {order[0], order[1], order[2], order[3]}, 4'b0101);
    @(posedge clk); #1;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (if_resp_valid) begin nif++; chk("alt/if_data", if_resp_data, ref_mem[4]); end
      if (ls_resp_valid) begin nls++; chk("alt/ls_data", ls_resp_data, ref_mem[9]); end
    end
    chk("alt/resp_counts", {nif[7:0], nls[7:0]}, 16'h0202);

    do_req(0, 0, 32'h0, 32'h0, 4'h0, "fetch0", d);
    chk("fetch0/word", d, 32'h00500093);

    do_req(1, 1, 32'h100, 32'hDEADBEEF, 4'hF, "store_full", d);
    do_req(1, 1, 32'h100, 32'h000000AA, 4'h1, "store_byte", d);
    do_req(1, 0, 32'h100, 32'h0, 4'h0, "load_merge", d);
    chk("load_merge/word", d, 32'hDEADBEAA);

    do_req(1, 0, 32'h102, 32'h0, 4'h0, "ls_misaligned", d);
    do_req(0, 0, 32'h3, 32'h0, 4'h0, "if_misaligned", d);
    do_req(0, 0, 32'hFFFC0004, 32'h0, 4'h0, "addr_trunc", d);
    chk("addr_trunc/mem_addr", last_en_addr, 18'h00004);

    // Reset while a load sits in WAIT: it must vanish without a response.
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h200;
    #1;
    for (int w = 0; w < 20 && !ls_req_ready; w++) @(negedge clk);
    chk("rst_wait/accept", ls_req_ready, 1);
    @(posedge clk); #1 ls_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wait/busy_before", busy, 1);
    rst = 1'b1;
    #1 chk("rst_wait/outputs", all_outs(), 0);
    en_snap = n_en;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nls = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (ls_resp_valid || if_resp_valid) nls++;
    end
    chk("rst_wait/no_resp", nls, 0);
    chk("rst_wait/no_mem_en", n_en - en_snap, 0);
    do_req(0, 0, 32'h0, 32'h0, 4'h0, "post_reset_fetch", d);
    chk("post_reset_fetch/word", d, 32'h00500093);

    for (int k = 0; k < 40; k++) begin
      rl  = 1'($urandom_range(0, 1));
      rwe = rl ? 1'($urandom_range(0, 1)) : 1'b0;
      a = $urandom();
      a[17:6] = 12'h0;
      a[5:2]  = 4'($urandom_range(0, 15));
      a[1:0]  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_req(rl, rwe, a, $urandom(), 4'($urandom_range(0, 15)), "rand", d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
